// File: rtl/apb_pkg.sv
// Shared types and helpers for the round-robin APB master and its arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW = 4;
    localparam int APB_DW = 8;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans eligible requesters starting at ptr and moves
// ptr just past the winner whenever a grant is taken.
module rr_arbiter
    import apb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic            en_i,
    output logic            valid_o,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] elig;

    // A requester completing this cycle is masked so a held req is not re-granted.
    assign elig = req_i & ~mask_i;

    // First eligible requester at or after ptr, wrapping once around the ring.
    always_comb begin
        int j;
        valid_o = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!valid_o && elig[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

    // Advance the pointer past the winner on every accepted grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en_i && valid_o) begin
            ptr_q <= (idx_o == IW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Shared APB master: round-robin arbitration between NREQ requesters,
// SETUP/ACCESS sequencing with wait states and a stall timeout.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    apb_state_e      state_q;
    logic [NREQ-1:0] owner_q;    // one-hot index of the in-flight requester
    logic            pwrite_q;
    logic [AW-1:0]   paddr_q;
    logic [DW-1:0]   pwdata_q;
    logic [CW-1:0]   wait_q;
    logic [NREQ-1:0] done_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            psel_q;
    logic            penable_q;

    logic            gnt_vld;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            timeout_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .mask_i  (done_q),
        .en_i    (state_q == ST_IDLE),
        .valid_o (gnt_vld),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    // This stalled ACCESS cycle is the TIMEOUT-th one: give up on the slave.
    assign timeout_hit = !pready && (wait_q == CW'(TIMEOUT - 1));

    // Transfer FSM; every bus and response output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            wait_q    <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        state_q  <= ST_SETUP;
                        owner_q  <= gnt;
                        pwrite_q <= req_wr[gnt_idx];
                        paddr_q  <= req_addr[gnt_idx*AW +: AW];
                        pwdata_q <= req_wdata[gnt_idx*DW +: DW];
                        wait_q   <= '0;
                        psel_q   <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (!pready && wait_q != CW'(TIMEOUT)) wait_q <= wait_q + 1'b1;
                    if (pready || timeout_hit) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        done_q    <= owner_q;
                        err_q     <= pready ? pslverr : 1'b1;
                        rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus a randomized run checked
// cycle by cycle against a transaction-level round-robin model.
module tb_apb_rr_master;

    localparam int NREQ = 4, AW = 4, DW = 8, TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    req_wr = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               err, psel, penable, pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [DW-1:0]      prdata = '0;
    logic               pready = 1'b0;
    logic               pslverr = 1'b0;

    int checks = 0, errors = 0;
    int cyc = 0;

    // Slave behaviour for the next transfer, set by the tests.
    int            slv_waits = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err = 1'b0;
    int            acc_cnt = 0;

    // Bus snapshot taken in SETUP, and a flag raised if ACCESS differs from it.
    int            su_cyc = -1;
    logic [AW-1:0] su_addr = '0;
    logic          su_wr = 1'b0;
    logic [DW-1:0] su_wdata = '0;
    bit            unstable = 1'b0;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: ready after slv_waits stalled ACCESS cycles; junk everywhere else.
    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = (acc_cnt == slv_waits);
            prdata  = pready ? slv_rdata : DW'($urandom);
            pslverr = pready ? slv_err : 1'($urandom);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = DW'($urandom);
        end
    end

    // Bus monitor: record SETUP contents and note any change during ACCESS.
    always @(negedge clk) begin
        if (psel && !penable) begin
            su_cyc = cyc; su_addr = paddr; su_wr = pwrite; su_wdata = pwdata;
        end else if (psel && penable && {paddr, pwrite, pwdata} !== {su_addr, su_wr, su_wdata}) begin
            unstable = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    // Step to the next cycle with a done pulse; returns zeros if none within max cycles.
    task automatic wait_done(input int max, output logic [NREQ-1:0] d, output logic [DW-1:0] rd, output logic e);
        d = '0; rd = '0; e = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (done !== '0) begin
                d = done; rd = rdata; e = err;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, done, rdata, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h done=%b rdata=%h err=%b, expected all zero",
                     psel, penable, pwrite, paddr, pwdata, done, rdata, err);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({psel, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got psel=%b done=%b err=%b with no requests, expected 0", psel, done, err);
        end
    endtask

    task automatic test_single_write();
        logic [NREQ-1:0] d; logic [DW-1:0] rd; logic e; int t0;
        slv_waits = 0; slv_err = 1'b0; slv_rdata = 8'h3C;
        @(negedge clk);
        unstable = 1'b0; su_cyc = -1; t0 = cyc;
        start_req(0, 1'b1, 4'd3, 8'hA5);
        wait_done(10, d, rd, e);
        checks++;
        if (d !== 4'b0001 || cyc - t0 != 3) begin
            errors++;
            $display("FAIL wr_done: got done=%b at cycle %0d, expected 0001 at cycle 3", d, cyc - t0);
        end
        checks++;
        if (e !== 1'b0 || rd !== 8'h00) begin
            errors++;
            $display("FAIL wr_resp: got err=%b rdata=%h, expected err=0 rdata=00", e, rd);
        end
        checks++;
        if (su_cyc - t0 != 1 || su_addr !== 4'd3 || su_wr !== 1'b1 || su_wdata !== 8'hA5 || unstable) begin
            errors++;
            $display("FAIL wr_bus: got setup cycle %0d addr=%h wr=%b wdata=%h unstable=%b, expected cycle 1 addr=3 wr=1 wdata=a5 stable",
                     su_cyc - t0, su_addr, su_wr, su_wdata, unstable);
        end
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== '0) begin
            errors++;
            $display("FAIL wr_idle_bus: got psel=%b pwrite=%b paddr=%h pwdata=%h in done cycle, expected all zero",
                     psel, pwrite, paddr, pwdata);
        end
        // req[0] stays high through the done cycle; it must not be granted again.
        @(negedge clk);
        req[0] = 1'b0;
        checks++;
        if (psel !== 1'b0 || done !== '0) begin
            errors++;
            $display("FAIL wr_regrant: got psel=%b done=%b after completion, expected psel=0 done=0000", psel, done);
        end
    endtask

    task automatic test_read_waits();
        logic [NREQ-1:0] d; logic [DW-1:0] rd; logic e; int t0;
        slv_waits = 3; slv_err = 1'b0; slv_rdata = 8'h7C;
        @(negedge clk);
        unstable = 1'b0; su_cyc = -1; t0 = cyc;
        start_req(2, 1'b0, 4'd1, 8'hEE);
        wait_done(12, d, rd, e);
        req[2] = 1'b0;
        checks++;
        if (d !== 4'b0100 || cyc - t0 != 6) begin
            errors++;
            $display("FAIL rd_wait_done: got done=%b at cycle %0d, expected 0100 at cycle 6", d, cyc - t0);
        end
        checks++;
        if (rd !== 8'h7C || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_wait_data: got rdata=%h err=%b, expected rdata=7c err=0", rd, e);
        end
        checks++;
        if (su_addr !== 4'd1 || su_wr !== 1'b0 || unstable) begin
            errors++;
            $display("FAIL rd_wait_bus: got addr=%h wr=%b unstable=%b, expected addr=1 wr=0 stable", su_addr, su_wr, unstable);
        end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] d; logic [DW-1:0] rd; logic e; int t0;
        slv_waits = 1000; slv_err = 1'b0; slv_rdata = 8'h55;
        @(negedge clk);
        t0 = cyc;
        start_req(3, 1'b0, 4'd9, 8'h00);
        wait_done(40, d, rd, e);
        req[3] = 1'b0;
        checks++;
        if (d !== 4'b1000 || cyc - t0 != 2 + TIMEOUT) begin
            errors++;
            $display("FAIL timeout_done: got done=%b at cycle %0d, expected 1000 at cycle %0d", d, cyc - t0, 2 + TIMEOUT);
        end
        checks++;
        if (e !== 1'b1 || rd !== 8'h00) begin
            errors++;
            $display("FAIL timeout_resp: got err=%b rdata=%h, expected err=1 rdata=00", e, rd);
        end
        @(negedge clk);
        checks++;
        if ({psel, penable, done} !== '0) begin
            errors++;
            $display("FAIL timeout_idle: got psel=%b penable=%b done=%b after abort, expected zeros", psel, penable, done);
        end
    endtask

    task automatic test_slave_error();
        logic [NREQ-1:0] d; logic [DW-1:0] rd; logic e; logic [DW-1:0] v;
        slv_waits = 0; slv_err = 1'b1; slv_rdata = 8'h11;
        @(negedge clk);
        start_req(1, 1'b1, 4'd7, 8'h42);
        wait_done(10, d, rd, e);
        req[1] = 1'b0;
        checks++;
        if (d !== 4'b0010 || e !== 1'b1 || rd !== 8'h00) begin
            errors++;
            $display("FAIL slverr_write: got done=%b err=%b rdata=%h, expected done=0010 err=1 rdata=00", d, e, rd);
        end
        v = DW'($urandom);
        slv_err = 1'b0; slv_rdata = v;
        @(negedge clk);
        start_req(0, 1'b0, 4'd2, 8'h00);
        wait_done(10, d, rd, e);
        req[0] = 1'b0;
        checks++;
        if (d !== 4'b0001 || e !== 1'b0 || rd !== v) begin
            errors++;
            $display("FAIL slverr_next: got done=%b err=%b rdata=%h, expected done=0001 err=0 rdata=%h", d, e, rd, v);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [NREQ-1:0] d; logic [DW-1:0] rd; logic e; logic [DW-1:0] v; int t0; bit saw_done;
        slv_waits = 1000; slv_err = 1'b0;
        @(negedge clk);
        start_req(2, 1'b0, 4'd5, 8'h00);
        repeat (4) @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_access: got psel=%b penable=%b before reset, expected 1 1", psel, penable);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got psel=%b penable=%b right after reset, expected 0 0", psel, penable);
        end
        req = '0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== '0) saw_done = 1'b1;
        end
        rst = 1'b0;
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL rstmid_nodone: got a done pulse for the aborted transfer, expected none");
        end
        // Pointer must be back at 0: with req[1] and req[3] both pending, 1 wins.
        v = DW'($urandom);
        slv_waits = 0; slv_rdata = v;
        t0 = cyc;
        start_req(3, 1'b1, 4'd4, 8'h99);
        start_req(1, 1'b0, 4'd6, 8'h00);
        wait_done(10, d, rd, e);
        req[1] = 1'b0;
        checks++;
        if (d !== 4'b0010 || cyc - t0 != 3 || rd !== v || e !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got done=%b at cycle %0d rdata=%h err=%b, expected 0010 at cycle 3 rdata=%h err=0",
                     d, cyc - t0, rd, e, v);
        end
        wait_done(10, d, rd, e);
        req[3] = 1'b0;
        checks++;
        if (d !== 4'b1000 || cyc - t0 != 6) begin
            errors++;
            $display("FAIL rstmid_second: got done=%b at cycle %0d, expected 1000 at cycle 6", d, cyc - t0);
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] d, xd; logic [DW-1:0] rd; logic e; int w, exp_cyc;
        do_reset();
        slv_err = 1'b0;
        w = $urandom_range(0, 2);
        slv_waits = w;
        for (int i = 0; i < NREQ; i++) start_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
        exp_cyc = cyc + 3 + w;
        for (int n = 0; n < 2 * NREQ; n++) begin
            wait_done(10, d, rd, e);
            xd = '0;
            xd[n % NREQ] = 1'b1;
            checks++;
            if (d !== xd || cyc != exp_cyc || e !== 1'b0) begin
                errors++;
                $display("FAIL contention_%0d: got done=%b err=%b at cycle offset %0d, expected done=%b err=0 offset 0",
                         n, d, e, cyc - exp_cyc, xd);
            end
            if (n == 2 * NREQ - 1) req = '0;
            w = $urandom_range(0, 2);
            slv_waits = w;
            exp_cyc = cyc + 3 + w;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL contention_drain: got psel=%b after all requests dropped, expected 0", psel);
        end
    endtask

    // Randomized traffic; model: round-robin from ptr over pending requesters not
    // completing this cycle, SETUP one cycle after grant, ACCESS until the slave's
    // ready (or TIMEOUT stalls), done the following cycle.
    task automatic test_random();
        int              m_ptr, owner, g, done_at, w, c;
        bit              busy, tmo, on_bus;
        logic [NREQ-1:0] drop_nxt, mask, x_done;
        logic            m_wr, m_err, x_err;
        logic [AW-1:0]   m_addr;
        logic [DW-1:0]   m_wdata, m_rdata, x_rdata;
        logic [AW+DW:0]  x_bus;
        do_reset();
        m_ptr = 0; busy = 1'b0; owner = 0; g = 0; done_at = -1; drop_nxt = '0;
        m_wr = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int n = 0; n < 600; n++) begin
            c = cyc;
            on_bus = busy && c > g && c < done_at;
            x_done = '0; x_rdata = '0; x_err = 1'b0;
            if (busy && c == done_at) begin
                x_done[owner] = 1'b1; x_rdata = m_rdata; x_err = m_err;
            end
            x_bus = on_bus ? {m_wr, m_addr, m_wdata} : '0;
            checks++;
            if ({done, rdata, err} !== {x_done, x_rdata, x_err} ||
                {psel, penable} !== {on_bus, on_bus && c > g + 1} ||
                {pwrite, paddr, pwdata} !== x_bus) begin
                errors++;
                $display("FAIL rand_step%0d: got done=%b rdata=%h err=%b psel=%b penable=%b bus=%h, expected done=%b rdata=%h err=%b psel=%b penable=%b bus=%h",
                         n, done, rdata, err, psel, penable, {pwrite, paddr, pwdata},
                         x_done, x_rdata, x_err, on_bus, on_bus && c > g + 1, x_bus);
            end
            req = req & ~drop_nxt;
            drop_nxt = '0;
            mask = '0;
            if (busy && c == done_at) begin
                busy = 1'b0;
                mask[owner] = 1'b1;
                drop_nxt[owner] = 1'b1;
            end
            // The owner may let go of req early; its transfer still completes.
            if (busy && req[owner] && $urandom_range(0, 15) == 0) req[owner] = 1'b0;
            if (n < 500) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req[i] && !drop_nxt[i] && !(busy && owner == i) && $urandom_range(0, 3) == 0)
                        start_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
                end
            end
            if (!busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (!busy && req[j] && !mask[j]) begin
                        owner = j; busy = 1'b1;
                    end
                end
                if (busy) begin
                    g = c;
                    m_ptr = (owner + 1) % NREQ;
                    m_wr = req_wr[owner];
                    m_addr = req_addr[owner*AW +: AW];
                    m_wdata = req_wdata[owner*DW +: DW];
                    w = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
                    tmo = (w >= TIMEOUT);
                    slv_waits = w;
                    slv_rdata = DW'($urandom);
                    slv_err = 1'($urandom);
                    done_at = tmo ? c + 2 + TIMEOUT : c + 3 + w;
                    m_err = tmo ? 1'b1 : slv_err;
                    m_rdata = (tmo || m_wr) ? '0 : slv_rdata;
                end
            end
            @(negedge clk);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_waits();
        test_timeout();
        test_slave_error();
        test_reset_mid_access();
        test_contention();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
